// File: rtl/dram_port_arbiter_if.sv
// rtl/dram_port_arbiter_if.sv - DRAM controller port bundle between the arbiter and the controller
interface dram_port_arbiter_if;
    logic         mem_req;
    logic         mem_we;
    logic [17:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [15:0]  mem_wstrb;
    logic         mem_ack;
    logic [511:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - rotating-priority arbiter sharing one DRAM port between
// program fills, data fills and the write-back FIFO drain
module dram_port_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                is_req_f_prog,
    input  logic [17:0]         req_addr_f_prog,
    input  logic                is_req_f_data,
    input  logic [17:0]         req_addr_f_data,
    input  logic                fifo_empty,
    input  logic [31:0]         write_back_addr,
    input  logic [31:0]         write_back_data,
    output logic                wb_pop,
    output logic                prog_fill_valid,
    output logic [511:0]        prog_fill_data,
    output logic                data_fill_valid,
    output logic [511:0]        data_fill_data,
    dram_port_arbiter_if.master mem,
    output logic                busy,
    output logic                timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    typedef enum logic [1:0] {G_P, G_W, G_D} grant_t;

    state_t       r_state;
    state_t       w_next_state;
    grant_t       r_grant;
    grant_t       r_last_grant;
    grant_t       w_sel;
    logic         w_cand_p;
    logic         w_cand_w;
    logic         w_cand_d;
    logic         w_any;
    logic         w_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic         r_mem_we;
    logic [17:0]  r_mem_addr;
    logic [31:0]  r_mem_wdata;
    logic [15:0]  r_mem_wstrb;
    logic         r_timeout_err;
    logic [511:0] r_prog_data;
    logic [511:0] r_data_data;
    logic         w_unused_addr_bits;

    // Data fills wait for an empty FIFO so they observe every earlier store.
    assign w_cand_p  = is_req_f_prog;
    assign w_cand_w  = !fifo_empty;
    assign w_cand_d  = is_req_f_data && fifo_empty;
    assign w_any     = w_cand_p || w_cand_w || w_cand_d;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    assign w_unused_addr_bits = ^{write_back_addr[31:24], write_back_addr[1:0]};

    always_comb begin
        w_sel = G_P;
        case (r_last_grant)
            G_P: begin
                if (w_cand_w)      w_sel = G_W;
                else if (w_cand_d) w_sel = G_D;
                else               w_sel = G_P;
            end
            G_W: begin
                if (w_cand_d)      w_sel = G_D;
                else if (w_cand_p) w_sel = G_P;
                else               w_sel = G_W;
            end
            default: begin
                if (w_cand_p)      w_sel = G_P;
                else if (w_cand_w) w_sel = G_W;
                else               w_sel = G_D;
            end
        endcase
    end

    always_comb begin
        w_next_state    = r_state;
        mem.mem_req     = 1'b0;
        busy            = 1'b0;
        prog_fill_valid = 1'b0;
        data_fill_valid = 1'b0;
        wb_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) w_next_state = ISSUE;
            end
            ISSUE: begin
                mem.mem_req = 1'b1;
                busy        = 1'b1;
                // An ack arriving on the timeout cycle still completes the transaction.
                if (mem.mem_ack)    w_next_state = DONE;
                else if (w_timeout) w_next_state = IDLE;
            end
            DONE: begin
                busy            = 1'b1;
                prog_fill_valid = (r_grant == G_P);
                data_fill_valid = (r_grant == G_D);
                wb_pop          = (r_grant == G_W);
                w_next_state    = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= G_D;
            r_last_grant  <= G_D;
            r_cnt         <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_timeout_err <= 1'b0;
            r_prog_data   <= '0;
            r_data_data   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_sel;
                        r_last_grant <= w_sel;
                        r_cnt        <= '0;
                        if (w_sel == G_W) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= write_back_addr[23:6];
                            r_mem_wdata <= write_back_data;
                            r_mem_wstrb <= 16'd1 << write_back_addr[5:2];
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= (w_sel == G_P) ? req_addr_f_prog : req_addr_f_data;
                            r_mem_wdata <= '0;
                            r_mem_wstrb <= '0;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem.mem_ack) begin
                        if (r_grant == G_P) r_prog_data <= mem.mem_rdata;
                        if (r_grant == G_D) r_data_data <= mem.mem_rdata;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_wstrb = r_mem_wstrb;
    assign timeout_err   = r_timeout_err;
    assign prog_fill_data = r_prog_data;
    assign data_fill_data = r_data_data;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - scoreboard bench for dram_port_arbiter, with a second
// instance at TIMEOUT=4 for the timeout scenario
module tb_dram_port_arbiter;

    localparam int K_P = 0;
    localparam int K_W = 1;
    localparam int K_D = 2;

    typedef struct {
        int          kind;
        logic        we;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [15:0] wstrb;
    } txn_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         is_req_f_prog;
    logic [17:0]  req_addr_f_prog;
    logic         is_req_f_data;
    logic [17:0]  req_addr_f_data;
    logic         fifo_empty;
    logic [31:0]  write_back_addr;
    logic [31:0]  write_back_data;

    logic         wb_pop, prog_fill_valid, data_fill_valid, busy, timeout_err;
    logic [511:0] prog_fill_data, data_fill_data;
    logic         wb_pop2, prog_fill_valid2, data_fill_valid2, busy2, timeout_err2;
    logic [511:0] prog_fill_data2, data_fill_data2;

    dram_port_arbiter_if mif();
    dram_port_arbiter_if mif2();

    dram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .is_req_f_prog(is_req_f_prog), .req_addr_f_prog(req_addr_f_prog),
        .is_req_f_data(is_req_f_data), .req_addr_f_data(req_addr_f_data),
        .fifo_empty(fifo_empty), .write_back_addr(write_back_addr), .write_back_data(write_back_data),
        .wb_pop(wb_pop), .prog_fill_valid(prog_fill_valid), .prog_fill_data(prog_fill_data),
        .data_fill_valid(data_fill_valid), .data_fill_data(data_fill_data),
        .mem(mif.master), .busy(busy), .timeout_err(timeout_err)
    );

    dram_port_arbiter #(.TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset),
        .is_req_f_prog(is_req_f_prog), .req_addr_f_prog(req_addr_f_prog),
        .is_req_f_data(is_req_f_data), .req_addr_f_data(req_addr_f_data),
        .fifo_empty(fifo_empty), .write_back_addr(write_back_addr), .write_back_data(write_back_data),
        .wb_pop(wb_pop2), .prog_fill_valid(prog_fill_valid2), .prog_fill_data(prog_fill_data2),
        .data_fill_valid(data_fill_valid2), .data_fill_data(data_fill_data2),
        .mem(mif2.master), .busy(busy2), .timeout_err(timeout_err2)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    bit          hold_reqs = 1'b0;
    txn_t        exp_q[$];
    logic [63:0] wb_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic update_fifo();
        fifo_empty = (wb_q.size() == 0);
        if (wb_q.size() != 0) {write_back_addr, write_back_data} = wb_q[0];
        else {write_back_addr, write_back_data} = '0;
    endtask

    function automatic txn_t mk_read(input int kind, input logic [17:0] addr);
        txn_t t;
        t.kind = kind; t.we = 1'b0; t.addr = addr; t.wdata = '0; t.wstrb = '0;
        return t;
    endfunction

    function automatic txn_t mk_write(input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.kind = K_W; t.we = 1'b1; t.addr = a[23:6]; t.wdata = d;
        t.wstrb = 16'd1 << a[5:2];
        return t;
    endfunction

    // Serves one DRAM transaction after `delay` stall cycles and scores it against exp_q.
    task automatic do_txn(input int delay, input logic [511:0] rdata);
        txn_t        e;
        int          n;
        logic [17:0] a0;
        logic [2:0]  epulse;
        n = 0;
        while (!mif.mem_req && n < 20) begin tick(); n++; end
        n_total++;
        if (mif.mem_req !== 1'b1) begin
            $display("FAIL txn_req: mem_req=%b required 1 within 20 cycles", mif.mem_req);
            return;
        end
        n_pass++;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL txn_unexpected: got grant addr=%h, scoreboard empty", mif.mem_addr);
            return;
        end
        e = exp_q.pop_front();
        if ({mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wstrb} !== {e.we, e.addr, e.wdata, e.wstrb})
            $display("FAIL txn_fields: we=%b addr=%h wdata=%h wstrb=%h required we=%b addr=%h wdata=%h wstrb=%h",
                     mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wstrb, e.we, e.addr, e.wdata, e.wstrb);
        else n_pass++;
        a0 = mif.mem_addr;
        for (int i = 0; i < delay; i++) begin
            tick();
            n_total++;
            if ({mif.mem_req, mif.mem_addr} !== {1'b1, a0})
                $display("FAIL txn_stable: req=%b addr=%h required req=1 addr=%h", mif.mem_req, mif.mem_addr, a0);
            else n_pass++;
        end
        mif.mem_ack = 1'b1;
        mif.mem_rdata = rdata;
        tick();
        mif.mem_ack = 1'b0;
        mif.mem_rdata = ~rdata;
        epulse = (e.kind == K_P) ? 3'b100 : (e.kind == K_D) ? 3'b010 : 3'b001;
        n_total++;
        if ({prog_fill_valid, data_fill_valid, wb_pop, busy, mif.mem_req} !== {epulse, 2'b10})
            $display("FAIL txn_done: pvalid/dvalid/pop/busy/req=%b required %b",
                     {prog_fill_valid, data_fill_valid, wb_pop, busy, mif.mem_req}, {epulse, 2'b10});
        else n_pass++;
        if (e.kind == K_P) begin
            n_total++;
            if (prog_fill_data !== rdata) $display("FAIL prog_fill_data: got %h required %h", prog_fill_data, rdata);
            else n_pass++;
            if (!hold_reqs) is_req_f_prog = 1'b0;
        end else if (e.kind == K_D) begin
            n_total++;
            if (data_fill_data !== rdata) $display("FAIL data_fill_data: got %h required %h", data_fill_data, rdata);
            else n_pass++;
            if (!hold_reqs) is_req_f_data = 1'b0;
        end else begin
            void'(wb_q.pop_front());
            update_fifo();
        end
        tick();
        n_total++;
        if ({prog_fill_valid, data_fill_valid, wb_pop} !== 3'b000)
            $display("FAIL pulse_width: pulses=%b required 000", {prog_fill_valid, data_fill_valid, wb_pop});
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        is_req_f_prog = 1'b0; is_req_f_data = 1'b0;
        req_addr_f_prog = '0; req_addr_f_data = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        mif2.mem_ack = 1'b0; mif2.mem_rdata = '0;
        wb_q.delete();
        update_fifo();
        tick(); tick();
        n_total++;
        if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wstrb, busy, timeout_err} !== '0)
            $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h wstrb=%h busy=%b terr=%b required all 0",
                     mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wstrb, busy, timeout_err);
        else n_pass++;
        n_total++;
        if ({prog_fill_valid, data_fill_valid, wb_pop} !== 3'b000)
            $display("FAIL reset_pulses: %b required 000", {prog_fill_valid, data_fill_valid, wb_pop});
        else n_pass++;
        n_total++;
        if ({prog_fill_data, data_fill_data} !== '0)
            $display("FAIL reset_fill: prog=%h data=%h required 0", prog_fill_data, data_fill_data);
        else n_pass++;
        reset = 1'b0;
        tick(); tick();
        n_total++;
        if ({busy, mif.mem_req} !== 2'b00) $display("FAIL idle_no_req: busy/req=%b required 00", {busy, mif.mem_req});
        else n_pass++;
    endtask

    task automatic test_priority();
        wb_q.push_back({32'h0000_1234, 32'hDEAD_BEEF});
        wb_q.push_back({32'hFF00_0FC8, 32'h1234_5678});
        update_fifo();
        req_addr_f_prog = 18'h00155; is_req_f_prog = 1'b1;
        req_addr_f_data = 18'h002AA; is_req_f_data = 1'b1;
        exp_q.push_back(mk_read(K_P, 18'h00155));
        exp_q.push_back(mk_write(32'h0000_1234, 32'hDEAD_BEEF));
        exp_q.push_back(mk_write(32'hFF00_0FC8, 32'h1234_5678));
        exp_q.push_back(mk_read(K_D, 18'h002AA));
        do_txn(0, {64{8'hA5}});
        do_txn(1, {16{32'h5555_AAAA}});
        do_txn(0, {16{32'h0F0F_0F0F}});
        do_txn(2, {16{32'h0123_4567}});
        n_total++;
        if (prog_fill_data !== {64{8'hA5}}) $display("FAIL prog_hold: got %h required %h", prog_fill_data, {64{8'hA5}});
        else n_pass++;
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL priority_left: %0d grants outstanding, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int n;
        req_addr_f_prog = 18'h003C3; is_req_f_prog = 1'b1;
        n = 0;
        while (!mif.mem_req && n < 10) begin tick(); n++; end
        n_total++;
        if (mif.mem_req !== 1'b1) $display("FAIL mid_reset_req: mem_req=%b required 1", mif.mem_req);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if ({mif.mem_req, busy, mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wstrb, timeout_err,
             prog_fill_valid, data_fill_valid, wb_pop} !== '0)
            $display("FAIL mid_reset_out: req=%b busy=%b we=%b addr=%h wdata=%h wstrb=%h required all 0",
                     mif.mem_req, busy, mif.mem_we, mif.mem_addr, mif.mem_wdata, mif.mem_wstrb);
        else n_pass++;
        n_total++;
        if ({prog_fill_data, data_fill_data} !== '0)
            $display("FAIL mid_reset_fill: prog=%h data=%h required 0", prog_fill_data, data_fill_data);
        else n_pass++;
        reset = 1'b0;
        wb_q.push_back({32'h0000_0040, 32'hCAFE_F00D});
        update_fifo();
        exp_q.push_back(mk_read(K_P, 18'h003C3));
        exp_q.push_back(mk_write(32'h0000_0040, 32'hCAFE_F00D));
        do_txn(0, {8{64'hFEED_0000_BEEF_1111}});
        do_txn(0, '0);
    endtask

    task automatic test_delay();
        bit seen;
        req_addr_f_data = 18'h01F0F; is_req_f_data = 1'b1;
        exp_q.push_back(mk_read(K_D, 18'h01F0F));
        do_txn(5, {32{16'h3C96}});
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (data_fill_valid || mif.mem_req) seen = 1'b1;
            tick();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL delay_repeat: extra valid or request seen=%b required 0", seen);
        else n_pass++;
    endtask

    task automatic test_alternate();
        hold_reqs = 1'b1;
        req_addr_f_prog = 18'h000AB; is_req_f_prog = 1'b1;
        req_addr_f_data = 18'h2BCDE; is_req_f_data = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk_read(K_P, 18'h000AB));
            exp_q.push_back(mk_read(K_D, 18'h2BCDE));
        end
        do_txn(0, {16{32'h1111_0000}});
        do_txn(1, {16{32'h2222_0000}});
        do_txn(0, {16{32'h3333_0000}});
        do_txn(2, {16{32'h4444_0000}});
        is_req_f_prog = 1'b0; is_req_f_data = 1'b0;
        hold_reqs = 1'b0;
        tick(); tick();
        n_total++;
        if ({exp_q.size() == 0, busy} !== 2'b10)
            $display("FAIL alternate_end: outstanding=%0d busy=%b required 0 and 0", exp_q.size(), busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int  n;
        bit  pulse_seen;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        req_addr_f_prog = 18'h00111; is_req_f_prog = 1'b1;
        req_addr_f_data = 18'h00222; is_req_f_data = 1'b1;
        n = 0;
        while (!mif2.mem_req && n < 10) begin tick(); n++; end
        pulse_seen = 1'b0;
        n = 0;
        while (mif2.mem_req && n < 20) begin
            n++;
            if (prog_fill_valid2 || data_fill_valid2 || wb_pop2) pulse_seen = 1'b1;
            tick();
        end
        if (prog_fill_valid2 || data_fill_valid2 || wb_pop2) pulse_seen = 1'b1;
        n_total++;
        if (n !== 4) $display("FAIL timeout_len: mem_req high %0d cycles, required 4", n);
        else n_pass++;
        n_total++;
        if ({timeout_err2, pulse_seen} !== 2'b10)
            $display("FAIL timeout_flag: timeout_err=%b pulse_seen=%b required 1 and 0", timeout_err2, pulse_seen);
        else n_pass++;
        n = 0;
        while (!mif2.mem_req && n < 10) begin
            if (prog_fill_valid2 || data_fill_valid2 || wb_pop2) pulse_seen = 1'b1;
            tick(); n++;
        end
        n_total++;
        if ({mif2.mem_req, mif2.mem_we, mif2.mem_addr, timeout_err2, pulse_seen} !== {1'b1, 1'b0, 18'h00222, 1'b1, 1'b0})
            $display("FAIL timeout_rotate: req=%b we=%b addr=%h terr=%b pulse=%b required req=1 we=0 addr=00222 terr=1 pulse=0",
                     mif2.mem_req, mif2.mem_we, mif2.mem_addr, timeout_err2, pulse_seen);
        else n_pass++;
        is_req_f_prog = 1'b0; is_req_f_data = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if ({timeout_err2, busy2, timeout_err} !== 3'b000)
            $display("FAIL timeout_clear: terr2/busy2/terr=%b required 000", {timeout_err2, busy2, timeout_err});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_mid_reset();
        test_delay();
        test_alternate();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
